// File: rtl/fc_vote_filter.sv
// fc_vote_filter: sliding-window majority vote over per-frame classifier results.
// Each rising edge of the classifier valid flag lands one class index in a 1-deep
// pending slot. The FSM then updates the history and histogram, scans the bins for
// the lowest-index maximum, and publishes the winner once its count reaches THRESH.
// Optional build macro: VOTE_CHANGE_ONLY_EN. When it is defined, a publish strobes
// only if the winner differs from the last published class, or if it is the first
// publish since reset or clear.
module fc_vote_filter #(
    parameter int unsigned NUM_CLASS = 27,
    parameter int unsigned WINDOW    = 8,
    parameter int unsigned THRESH    = 5,
    parameter int unsigned CW        = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_fc_result_out_valid,
    input  logic [4:0]    i_fc_result_out,
    output logic          o_vote_valid,
    output logic [4:0]    o_vote_class,
    output logic [CW-1:0] o_vote_count,
    output logic [CW-1:0] o_fill,
    output logic          o_busy,
    output logic          o_overflow
);

    localparam int unsigned CLS_W = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UPDATE  = 2'd1,
        S_SCAN    = 2'd2,
        S_PUBLISH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic               pend_q, pend_d;
    logic [CLS_W-1:0]   pend_cls_q, pend_cls_d;
    logic [CLS_W-1:0]   new_cls_q, new_cls_d;
    logic [CLS_W-1:0]   win_q [WINDOW];
    logic [CLS_W-1:0]   win_d [WINDOW];
    logic [CW-1:0]      hist_q [NUM_CLASS];
    logic [CW-1:0]      hist_d [NUM_CLASS];
    logic [CW-1:0]      fill_q, fill_d;
    logic [CLS_W-1:0]   scan_k_q, scan_k_d;
    logic [CLS_W-1:0]   best_cls_q, best_cls_d;
    logic [CW-1:0]      best_cnt_q, best_cnt_d;
    logic               vote_valid_q, vote_valid_d;
    logic [CLS_W-1:0]   vote_cls_q, vote_cls_d;
    logic [CW-1:0]      vote_cnt_q, vote_cnt_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
`ifdef VOTE_CHANGE_ONLY_EN
    logic               pub_seen_q, pub_seen_d;
`endif

    logic               event_c;
    logic               in_range_c;
    logic               publish_c;
    logic [CLS_W-1:0]   evict_c;

    assign event_c    = i_fc_result_out_valid & ~valid_q;
    assign in_range_c = 32'(i_fc_result_out) < NUM_CLASS;
    assign evict_c    = win_q[WINDOW-1];

    // Publish qualification for the current scan result
`ifdef VOTE_CHANGE_ONLY_EN
    assign publish_c = (best_cnt_q >= CW'(THRESH)) &&
                       (!pub_seen_q || (best_cls_q != vote_cls_q));
`else
    assign publish_c = (best_cnt_q >= CW'(THRESH));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath updates, event capture and clear
    always_comb begin
        state_d      = state_q;
        valid_d      = i_fc_result_out_valid;
        pend_d       = pend_q;
        pend_cls_d   = pend_cls_q;
        new_cls_d    = new_cls_q;
        win_d        = win_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        scan_k_d     = scan_k_q;
        best_cls_d   = best_cls_q;
        best_cnt_d   = best_cnt_q;
        vote_valid_d = 1'b0;
        vote_cls_d   = vote_cls_q;
        vote_cnt_d   = vote_cnt_q;
        ovf_d        = ovf_q;
`ifdef VOTE_CHANGE_ONLY_EN
        pub_seen_d   = pub_seen_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    new_cls_d = pend_cls_q;
                    pend_d    = 1'b0;
                    state_d   = S_UPDATE;
                end
            end
            S_UPDATE: begin
                for (int i = 1; i < int'(WINDOW); i++) begin
                    win_d[i] = win_q[i-1];
                end
                win_d[0] = new_cls_q;
                if (fill_q == CW'(WINDOW)) begin
                    // Equal new and evicted classes leave the bin unchanged
                    if (evict_c != new_cls_q) begin
                        hist_d[new_cls_q] = hist_q[new_cls_q] + CW'(1);
                        hist_d[evict_c]   = hist_q[evict_c] - CW'(1);
                    end
                end else begin
                    hist_d[new_cls_q] = hist_q[new_cls_q] + CW'(1);
                    fill_d            = fill_q + CW'(1);
                end
                scan_k_d   = '0;
                best_cls_d = '0;
                best_cnt_d = '0;
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                // Strict compare keeps the lowest index on ties
                if (hist_q[scan_k_q] > best_cnt_q) begin
                    best_cnt_d = hist_q[scan_k_q];
                    best_cls_d = scan_k_q;
                end
                if (scan_k_q == CLS_W'(NUM_CLASS - 1)) begin
                    state_d = S_PUBLISH;
                end else begin
                    scan_k_d = scan_k_q + CLS_W'(1);
                end
            end
            S_PUBLISH: begin
                if (publish_c) begin
                    vote_valid_d = 1'b1;
                    vote_cls_d   = best_cls_q;
                    vote_cnt_d   = best_cnt_q;
`ifdef VOTE_CHANGE_ONLY_EN
                    pub_seen_d   = 1'b1;
`endif
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // New result goes to the pending slot unless it is still occupied
        if (event_c && in_range_c) begin
            if (pend_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_cls_d = i_fc_result_out;
            end
        end

        // Clear flushes everything except the last published result
        if (i_clear) begin
            state_d      = S_IDLE;
            pend_d       = 1'b0;
            win_d        = '{default: '0};
            hist_d       = '{default: '0};
            fill_d       = '0;
            ovf_d        = 1'b0;
            vote_valid_d = 1'b0;
`ifdef VOTE_CHANGE_ONLY_EN
            pub_seen_d   = 1'b0;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_cls_q   <= '0;
            new_cls_q    <= '0;
            win_q        <= '{default: '0};
            hist_q       <= '{default: '0};
            fill_q       <= '0;
            scan_k_q     <= '0;
            best_cls_q   <= '0;
            best_cnt_q   <= '0;
            vote_valid_q <= 1'b0;
            vote_cls_q   <= '0;
            vote_cnt_q   <= '0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef VOTE_CHANGE_ONLY_EN
            pub_seen_q   <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            pend_cls_q   <= pend_cls_d;
            new_cls_q    <= new_cls_d;
            win_q        <= win_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            scan_k_q     <= scan_k_d;
            best_cls_q   <= best_cls_d;
            best_cnt_q   <= best_cnt_d;
            vote_valid_q <= vote_valid_d;
            vote_cls_q   <= vote_cls_d;
            vote_cnt_q   <= vote_cnt_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
`ifdef VOTE_CHANGE_ONLY_EN
            pub_seen_q   <= pub_seen_d;
`endif
        end
    end

    assign o_vote_valid = vote_valid_q;
    assign o_vote_class = vote_cls_q;
    assign o_vote_count = vote_cnt_q;
    assign o_fill       = fill_q;
    assign o_busy       = busy_q;
    assign o_overflow   = ovf_q;

endmodule
